// File: rtl/booth_seq_pkg.sv
// Shared types and constants for the Booth multiplier issue/collect sequencer.
package booth_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int CNT_W = 8;

    function automatic int mul_lat(input int nb);
        return nb / 2 + 1;
    endfunction

endpackage

// File: rtl/booth_seq_fifo.sv
// Synchronous FIFO holding pending {a, b, tag} jobs; head is presented on dout while not empty.
module booth_seq_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [PW:0]      count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign do_push_s = push & ~full;
    assign do_pop_s  = pop & ~empty;
    assign full      = (count_r == (PW+1)'(DEPTH));
    assign empty     = (count_r == {(PW+1){1'b0}});
    assign dout      = mem_r[rd_ptr_r];

    // Entry storage; contents are only meaningful below the count.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers and occupancy; depth is a power of two so pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {(PW+1){1'b0}};
        end else begin
            if (do_push_s) wr_ptr_r <= wr_ptr_r + PW'(1);
            if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + (PW+1)'(1);
                2'b01:   count_r <= count_r - (PW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/booth_mul_sequencer.sv
// Issue/collect stage around a sequential radix-4 Booth multiplier, one job in flight.
// Optional BOOTH_SEQ_ZERO_BYPASS_EN: jobs with a zero operand skip the multiplier.
module booth_mul_sequencer
    import booth_seq_pkg::*;
#(
    parameter int NB         = 8,
    parameter int TAG_W      = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int MUL_LAT    = mul_lat(NB)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [NB-1:0]     in_a,
    input  logic [NB-1:0]     in_b,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2*NB-1:0]   out_product,
    output logic [TAG_W-1:0]  out_tag,
    output logic              mul_start,
    output logic [NB-1:0]     mul_a,
    output logic [NB-1:0]     mul_b,
    input  logic [2*NB-1:0]   mul_product
);
    localparam int FW = 2 * NB + TAG_W;

    state_e             state_r, state_s;
    logic [CNT_W-1:0]   cnt_r;
    logic               alive_r;
    logic               bypass_r;
    logic [TAG_W-1:0]   tag_r;
    logic               fifo_full_s, fifo_empty_s, push_s;
    logic               pop_s, start_s, capture_s, load_cnt_s, zero_s;
    logic [FW-1:0]      fifo_dout_s;
    logic [NB-1:0]      head_a_s, head_b_s;
    logic [TAG_W-1:0]   head_tag_s;

    assign in_ready = alive_r & ~fifo_full_s;
    assign push_s   = in_valid & in_ready;
    assign {head_a_s, head_b_s, head_tag_s} = fifo_dout_s;

`ifdef BOOTH_SEQ_ZERO_BYPASS_EN
    assign zero_s = (head_a_s == {NB{1'b0}}) | (head_b_s == {NB{1'b0}});
`else
    assign zero_s = 1'b0;
`endif

    booth_seq_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_s),
        .pop   (pop_s),
        .din   ({in_a, in_b, in_tag}),
        .dout  (fifo_dout_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_r <= IDLE;
        else        state_r <= state_s;
    end

    // FSM next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (!fifo_empty_s) state_s = zero_s ? DONE : START;
                else               state_s = IDLE;
            end
            START: state_s = WAIT;
            WAIT: begin
                if (cnt_r <= CNT_W'(1)) state_s = DONE;
                else                    state_s = WAIT;
            end
            DONE: begin
                if (!out_valid || out_ready) state_s = IDLE;
                else                         state_s = DONE;
            end
            default: state_s = IDLE;
        endcase
    end

    // FSM control decode.
    always_comb begin
        pop_s      = 1'b0;
        start_s    = 1'b0;
        capture_s  = 1'b0;
        load_cnt_s = 1'b0;
        case (state_r)
            IDLE: begin
                pop_s   = ~fifo_empty_s;
                start_s = ~fifo_empty_s & ~zero_s;
            end
            START:   load_cnt_s = 1'b1;
            WAIT:    load_cnt_s = 1'b0;
            DONE:    capture_s  = ~out_valid | out_ready;
            default: load_cnt_s = 1'b0;
        endcase
    end

    // Issue side: start pulse lands in START; operands held until the next pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alive_r   <= 1'b0;
            mul_start <= 1'b0;
            mul_a     <= {NB{1'b0}};
            mul_b     <= {NB{1'b0}};
            tag_r     <= {TAG_W{1'b0}};
            bypass_r  <= 1'b0;
            cnt_r     <= {CNT_W{1'b0}};
        end else begin
            alive_r   <= 1'b1;
            mul_start <= start_s;
            if (start_s) begin
                mul_a <= head_a_s;
                mul_b <= head_b_s;
            end
            if (pop_s) begin
                tag_r    <= head_tag_s;
                bypass_r <= zero_s;
            end
            if (load_cnt_s)
                cnt_r <= CNT_W'(MUL_LAT);
            else if (state_r == WAIT && cnt_r != {CNT_W{1'b0}})
                cnt_r <= cnt_r - CNT_W'(1);
        end
    end

    // Result register; a capture overrides the consume-clear so results can go back to back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_product <= {(2*NB){1'b0}};
            out_tag     <= {TAG_W{1'b0}};
        end else if (capture_s) begin
            out_valid   <= 1'b1;
            out_product <= bypass_r ? {(2*NB){1'b0}} : mul_product;
            out_tag     <= tag_r;
        end else if (out_valid && out_ready) begin
            out_valid   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_booth_mul_sequencer.sv
// Directed self-checking bench for booth_mul_sequencer with a behavioural multiplier stand-in.
module tb_booth_mul_sequencer;
    localparam int NB      = 8;
    localparam int TAG_W   = 4;
    localparam int MUL_LAT = NB / 2 + 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid, in_ready, out_valid, out_ready, mul_start;
    logic [NB-1:0]     in_a, in_b, mul_a, mul_b;
    logic [TAG_W-1:0]  in_tag, out_tag;
    logic [2*NB-1:0]   out_product;
    logic [2*NB-1:0]   mul_product = 16'h0000;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int t0, k, exp_c;
    logic [15:0] res_p[$];
    logic [3:0]  res_t[$];
    int          res_c[$];
    logic [15:0] held_p;
    logic [3:0]  held_t;
    logic [15:0] job_p[6];

    booth_mul_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_product(out_product), .out_tag(out_tag),
        .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
        .mul_product(mul_product)
    );

    always #5 clk = ~clk;

    // Multiplier stand-in: product becomes valid exactly when the sequencer reaches DONE.
    logic [NB-1:0] ma_q = 8'h00, mb_q = 8'h00;
    int mcnt = 0;
    always @(posedge clk) begin
        if (mul_start) begin
            ma_q        <= mul_a;
            mb_q        <= mul_b;
            mcnt        <= MUL_LAT;
            mul_product <= 16'hA5A5;
        end else if (mcnt != 0) begin
            mcnt <= mcnt - 1;
            if (mcnt == 1)
                mul_product <= 16'($signed({{8{ma_q[7]}}, ma_q}) * $signed({{8{mb_q[7]}}, mb_q}));
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: records input handshakes and accepted results, then samples 1ns after the edge.
    task automatic tick();
        logic pushed, got;
        pushed = in_valid && in_ready;
        got    = out_valid && out_ready;
        if (got) begin
            res_p.push_back(out_product);
            res_t.push_back(out_tag);
            res_c.push_back(cyc);
        end
        @(posedge clk);
        #1;
        cyc++;
        if (pushed) in_valid = 1'b0;
    endtask

    task automatic offer(input logic [7:0] a, input logic [7:0] b, input logic [3:0] t);
        in_a = a; in_b = b; in_tag = t; in_valid = 1'b1;
    endtask

    task automatic clear_results();
        res_p.delete(); res_t.delete(); res_c.delete();
    endtask

    initial begin
        rst_n = 1'b1; in_valid = 1'b0; in_a = 8'h00; in_b = 8'h00; in_tag = 4'h0; out_ready = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("rst_in_ready",  in_ready,    1'b0);
        check("rst_out_valid", out_valid,   1'b0);
        check("rst_mul_start", mul_start,   1'b0);
        tick(); tick();
        #2 rst_n = 1'b1;
        tick();
        check("rel_in_ready", in_ready, 1'b1);

        // Single job -3 x 7, latency and start pulse position
        out_ready = 1'b1;
        clear_results();
        t0 = cyc;
        offer(8'hFD, 8'h07, 4'h3);
        for (int c = 0; c <= 10; c++) begin
            check($sformatf("j1_start_c%0d", c), mul_start, (c == 2));
            check($sformatf("j1_valid_c%0d", c), out_valid, (c == 9));
            if (c == 9) begin
                check("j1_product", out_product, 16'hFFEB);
                check("j1_tag",     out_tag,     4'h3);
            end
            tick();
        end

        // Corner operands back to back
        clear_results();
        t0 = cyc;
        offer(8'h7F, 8'h80, 4'h5); tick();
        offer(8'h80, 8'h80, 4'h6); tick();
        k = 0;
        while (res_p.size() < 2 && k < 40) begin tick(); k++; end
        check("bb_count", res_p.size(), 2);
        if (res_p.size() == 2) begin
            check("bb_p0",  res_p[0], 16'hC080);
            check("bb_t0",  res_t[0], 4'h5);
            check("bb_c0",  res_c[0] - t0, 9);
            check("bb_p1",  res_p[1], 16'h4000);
            check("bb_t1",  res_t[1], 4'h6);
            check("bb_gap", res_c[1] - res_c[0], 8);
        end

        // Six jobs with the consumer stalled
        out_ready = 1'b0;
        clear_results();
        job_p = '{16'h0002, 16'h0001, 16'hFED4, 16'hFFC1, 16'h09C4, 16'hC080};
        for (int i = 0; i < 6; i++) begin
            case (i)
                0: offer(8'h01, 8'h02, 4'h1);
                1: offer(8'hFF, 8'hFF, 4'h2);
                2: offer(8'h64, 8'hFD, 4'h3);
                3: offer(8'hF9, 8'h09, 4'h4);
                4: offer(8'h32, 8'h32, 4'h5);
                default: offer(8'h80, 8'h7F, 4'h6);
            endcase
            if (i == 5) check("full_in_ready", in_ready, 1'b0);
            else begin
                k = 0;
                while (in_valid && k < 10) begin tick(); k++; end
                check($sformatf("push%0d_done", i), in_valid, 1'b0);
            end
        end
        k = 0;
        while (!out_valid && k < 20) begin tick(); k++; end
        check("stall_valid_seen", out_valid, 1'b1);
        for (int i = 0; i < 12; i++) tick();
        held_p = out_product;
        held_t = out_tag;
        check("stall_held_p", held_p, 16'h0002);
        for (int i = 0; i < 20; i++) begin
            tick();
            check("stall_p",     out_product, held_p);
            check("stall_t",     out_tag,     held_t);
            check("stall_valid", out_valid,   1'b1);
            check("stall_start", mul_start,   1'b0);
            check("stall_ready", in_ready,    1'b0);
        end
        out_ready = 1'b1;
        k = 0;
        while (res_p.size() < 6 && k < 100) begin tick(); k++; end
        check("six_count", res_p.size(), 6);
        for (int i = 0; i < res_p.size() && i < 6; i++) begin
            check($sformatf("six_p%0d", i), res_p[i], job_p[i]);
            check($sformatf("six_t%0d", i), res_t[i], 4'(i + 1));
        end

        // Reset during WAIT, then a fresh job at standard latency
        clear_results();
        offer(8'h05, 8'h06, 4'h9);
        for (int i = 0; i < 4; i++) tick();
        rst_n = 1'b0;
        #1;
        check("mid_out_valid", out_valid,   1'b0);
        check("mid_product",   out_product, 16'h0000);
        check("mid_tag",       out_tag,     4'h0);
        check("mid_start",     mul_start,   1'b0);
        check("mid_mul_a",     mul_a,       8'h00);
        check("mid_mul_b",     mul_b,       8'h00);
        check("mid_in_ready",  in_ready,    1'b0);
        tick();
        #2 rst_n = 1'b1;
        tick();
        check("mid_rel_ready", in_ready, 1'b1);
        for (int i = 0; i < 12; i++) tick();
        check("mid_discarded", res_p.size(), 0);
        t0 = cyc;
        offer(8'hF7, 8'h0B, 4'hA);
        for (int c = 0; c <= 9; c++) begin
            check($sformatf("post_valid_c%0d", c), out_valid, (c == 9));
            if (c == 9) begin
                check("post_product", out_product, 16'hFF9D);
                check("post_tag",     out_tag,     4'hA);
            end
            tick();
        end

        // Zero operand job
`ifdef BOOTH_SEQ_ZERO_BYPASS_EN
        exp_c = 3;
`else
        exp_c = 9;
`endif
        offer(8'h00, 8'hFB, 4'hC);
        for (int c = 0; c <= 10; c++) begin
            check($sformatf("zero_valid_c%0d", c), out_valid, (c == exp_c));
            check($sformatf("zero_start_c%0d", c), mul_start, (exp_c == 9 && c == 2));
            if (c == exp_c) begin
                check("zero_product", out_product, 16'h0000);
                check("zero_tag",     out_tag,     4'hC);
            end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/booth_mul_sequencer.md
# booth_mul_sequencer

Issue/collect stage wrapped around the sequential radix-4 Booth multiplier: accepts tagged signed operand pairs on a valid/ready stream, buffers them in a small FIFO, and drives the multiplier's start/A/B inputs one job at a time. It waits out the multiplier latency, captures the signed product, and returns it with its tag on a valid/ready output stream. Only one multiplication is in flight at a time, so results leave in input order.

## Interface
- `NB`, 8: operand width; two's complement.
- `TAG_W`, 4: width of the opaque tag carried with each job.
- `FIFO_DEPTH`, 4: input FIFO entries; a power of two, at least 2.
- `MUL_LAT`, `NB/2+1`: cycles waited after the start cycle before the product is sampled.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `in_valid` in 1: job offered.
- `in_ready` out 1: FIFO not full.
- `in_a`, `in_b` in NB: multiplicand and multiplier.
- `in_tag` in TAG_W: job tag.
- `out_valid` out 1: result held.
- `out_ready` in 1: consumer accepts.
- `out_product` out 2*NB: signed product.
- `out_tag` out TAG_W: tag of that product.
- `mul_start` out 1: one-cycle load pulse to the multiplier.
- `mul_a`, `mul_b` out NB: registered operands to the multiplier.
- `mul_product` in 2*NB: multiplier result.

## Operation
- The input handshake fires when `in_valid` and `in_ready` are both high; `{in_a, in_b, in_tag}` is pushed into the FIFO.
- `in_ready` is `!full`, driven from registered FIFO state.
- FSM states:
  - IDLE: if the FIFO is not empty, pop the head into `mul_a`/`mul_b` and the tag register, then go to START.
  - START: `mul_start`=1 for exactly this cycle, then go to WAIT with the counter loaded to `MUL_LAT`.
  - WAIT: decrement the counter; at 1, go to DONE.
  - DONE: if `!out_valid || out_ready`, capture `mul_product` and the tag into the output register, set `out_valid`, and go to IDLE. Otherwise stay in DONE; the multiplier holds its product until the next start.
- `mul_a`/`mul_b` are held stable from START until the next pop.
- The output register clears `out_valid` on `out_valid && out_ready` unless a DONE capture occurs in the same cycle; capture wins, so back-to-back results are possible.
- A push into an empty FIFO is not visible to IDLE until the following cycle; there is no fall-through.
- Arithmetic: the block does no maths of its own. `out_product` is exactly `mul_product`, interpreted as signed 2*NB.
- Reset, asynchronous and including mid-job:
  - FSM returns to IDLE, FIFO pointers and count clear, counter clears.
  - `in_ready`=0 while `rst_n` is low, then 1 from the first cycle after release.
  - `out_valid`=0, `out_product`=0, `out_tag`=0, `mul_start`=0, `mul_a`=0, `mul_b`=0.
  - An in-flight job is discarded; the multiplier needs no reset because every use is preceded by a start.

## Timing
- Job latency: input handshake in cycle 0 → pop at the end of cycle 1 → START in cycle 2 → WAIT in cycles 3..2+`MUL_LAT` → DONE in cycle 3+`MUL_LAT` → `out_valid` high in cycle 4+`MUL_LAT`. For NB=8 that is cycle 9.
- Throughput: one job per 3+`MUL_LAT` cycles when `out_ready` is held high.
- When the FIFO is full, `in_ready` is low; a pop and a push request in the same cycle do not push, because `in_ready` was already low.
- Output stall: the FSM waits in DONE indefinitely with no loss of data.

## Configuration
- `BOOTH_SEQ_ZERO_BYPASS_EN` defined: in IDLE, a popped job with `in_a==0` or `in_b==0` skips START and WAIT and goes straight to DONE.
  - DONE captures 0 instead of `mul_product`.
  - `mul_start` is not pulsed and `mul_a`/`mul_b` are not updated.
  - Result `out_valid` rises in cycle 3 after the input handshake.
- Not defined: zero operands take the normal path and latency.

## Structure
- Package `booth_seq_pkg`: FSM state enum (IDLE, START, WAIT, DONE), default-latency function `mul_lat(nb)`, counter width constant.
- Sub-module `booth_seq_fifo`: synchronous FIFO, parameters width and depth, with push/pop/full/empty.

## Test plan
- NB=8, one job `in_a`=8'hFD (-3), `in_b`=8'h07, tag 3 in cycle 0 → `mul_start` pulses in cycle 2 only; `out_valid` in cycle 9 with `out_product`=16'hFFEB, `out_tag`=3.
- Corner operands 127×-128 and -128×-128 back-to-back → 16'hC080 then 16'h4000, tags in order, the second result 8 cycles after the first.
- Push 6 jobs while `out_ready`=0 → `in_ready` falls after the FIFO holds 4 and the fifth job is in flight; nothing is lost after `out_ready` rises, all 6 products are correct and in order.
- `out_ready` low for 20 cycles with a result waiting → `out_product`/`out_tag` are stable, the FSM stays in DONE, and `mul_start` does not pulse.
- `rst_n` pulsed low during WAIT → all outputs are 0 immediately; a new job issued after release gives the correct product at the standard latency.
- With `BOOTH_SEQ_ZERO_BYPASS_EN`, job 0×-5 → `out_product`=0 in cycle 3 with no `mul_start` pulse; without the macro, the same job gives 0 in cycle 9.
